seq_detect_prog: RTL and testbench

- Parametrised Moore serial pattern detector, successor to the fixed-pattern FSM detectors in the FSM library.
- Pattern (up to PAT_W bits) and length are runtime-programmable, and overlapping vs non-overlapping detection is selectable.
- Adds a sample-enable, a config-load strobe and a saturating match counter.
- Sits on a 1-bit serial input stream and drives a one-cycle match flag plus a count for status logic.

---
 rtl/seq_detect_prog.sv | 110 +++++++++++
 tb/tb_seq_detect_prog.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_prog
// Purpose  : Runtime-programmable Moore serial pattern detector. Holds a
//            pattern of up to PAT_W bits and a length, selectable overlapping
//            or non-overlapping detection, a sample enable, and a saturating
//            match counter.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous active-high reset
//            signal     - serial data bit, sampled when en=1
//            en         - sample enable
//            cfg_load   - strobe: capture pattern/pat_len/overlap, clear state
//            pattern    - pattern bits, [pat_len-1] received first, [0] last
//            pat_len    - pattern length in bits (0 = detector idle)
//            overlap    - 1 = overlapping detection, 0 = non-overlapping
//            out        - registered one-cycle match flag
//            match_cnt  - saturating count of matches
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_prog #(
    parameter int               PAT_W   = 8,
    parameter int               LEN_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] PAT_RST = 'h1B,
    parameter int               LEN_RST = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signal,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               c_fill_w  = $clog2(PAT_W + 1);
    localparam logic [c_fill_w-1:0] c_fill_max = c_fill_w'(PAT_W);
    localparam logic [LEN_W-1:0] c_len_rst = LEN_W'((LEN_RST > PAT_W) ? PAT_W : LEN_RST);

    logic [PAT_W-1:0]    r_cfg_pat;
    logic [LEN_W-1:0]    r_cfg_len;
    logic                r_cfg_ovl;
    logic [PAT_W-1:0]    r_hist;
    logic [c_fill_w-1:0] r_fill;
    logic                r_out;
    logic [CNT_W-1:0]    r_cnt;

    logic [PAT_W-1:0]    w_hist_n;
    logic [c_fill_w-1:0] w_fill_n;
    logic [PAT_W-1:0]    w_mask;
    logic [LEN_W-1:0]    w_len_clamped;
    logic                w_match;

    // Clamp the requested length at capture time so the compare logic only
    // ever sees 0..PAT_W.
    assign w_len_clamped = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;

    always_comb begin
        w_hist_n = {r_hist[PAT_W-2:0], signal};
        w_fill_n = (r_fill == c_fill_max) ? r_fill : r_fill + 1'b1;
        // Mask selects the low L bits of history and pattern.
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(r_cfg_len));
        end
        w_match = (r_cfg_len != '0) &&
                  (int'(w_fill_n) >= int'(r_cfg_len)) &&
                  (((w_hist_n ^ r_cfg_pat) & w_mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_pat <= PAT_RST;
            r_cfg_len <= c_len_rst;
            r_cfg_ovl <= 1'b0;
            r_hist    <= '0;
            r_fill    <= '0;
            r_out     <= 1'b0;
            r_cnt     <= '0;
        end else if (cfg_load) begin
            // cfg_load wins over en: the serial bit of this cycle is dropped.
            r_cfg_pat <= pattern;
            r_cfg_len <= w_len_clamped;
            r_cfg_ovl <= overlap;
            r_hist    <= '0;
            r_fill    <= '0;
            r_out     <= 1'b0;
            r_cnt     <= '0;
        end else if (en) begin
            r_hist <= w_hist_n;
            // Non-overlapping mode restarts the search after a hit by
            // invalidating the history; hist itself keeps shifting.
            r_fill <= (w_match && !r_cfg_ovl) ? '0 : w_fill_n;
            r_out  <= w_match;
            if (w_match && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_out <= 1'b0;
        end
    end

    assign out       = r_out;
    assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_prog
// Purpose  : Self-checking bench for seq_detect_prog. A table of directed
//            vectors with hand-computed out/match_cnt, followed by
//            hand-written sequences for idle length, saturation, load
//            priority and mid-pattern reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_prog;

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic       ld;
        logic       sig;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       exp_out;
        logic [7:0] exp_cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       signal = 1'b0;
    logic       en = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [3:0] pat_len = 4'd0;
    logic       overlap = 1'b0;
    logic       out;
    logic [7:0] match_cnt;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    seq_detect_prog dut (
        .clk       (clk),
        .rst       (rst),
        .signal    (signal),
        .en        (en),
        .cfg_load  (cfg_load),
        .pattern   (pattern),
        .pat_len   (pat_len),
        .overlap   (overlap),
        .out       (out),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic add(input string nm, input logic r, input logic e, input logic l,
                       input logic s, input logic [7:0] p, input logic [3:0] n,
                       input logic o, input logic eo, input logic [7:0] ec);
        vec_t v;
        v.name = nm; v.rst = r; v.en = e; v.ld = l; v.sig = s;
        v.pat = p; v.len = n; v.ovl = o; v.exp_out = eo; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, clock it, then sample #1 after the edge.
    task automatic step(input logic r, input logic e, input logic l, input logic s,
                        input logic [7:0] p, input logic [3:0] n, input logic o);
        rst = r; en = e; cfg_load = l; signal = s;
        pattern = p; pat_len = n; overlap = o;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic eo, input logic [7:0] ec);
        checks++;
        if (out !== eo) begin
            errors++;
            $display("FAIL %s out: got %0b expected %0b", nm, out, eo);
        end
        checks++;
        if (match_cnt !== ec) begin
            errors++;
            $display("FAIL %s match_cnt: got %0d expected %0d", nm, match_cnt, ec);
        end
    endtask

    // Sample with en=1 and no load.
    task automatic bit_in(input string nm, input logic s, input logic eo, input logic [7:0] ec);
        step(1'b0, 1'b1, 1'b0, s, 8'h00, 4'd0, 1'b0);
        check(nm, eo, ec);
    endtask

    initial begin
        logic [9:0] t1;
        logic [7:0] t2;
        logic [7:0] a5;
        logic [6:0] a5b;

        // ---- 1: reset defaults (11011), non-overlap
        add("t1_rst", 1, 0, 0, 0, 8'h00, 4'd0, 0, 0, 8'd0);
        t1 = 10'b1101111011;
        for (int i = 9; i >= 0; i--) begin
            add($sformatf("t1_bit%0d", 10 - i), 0, 1, 0, t1[i], 8'h00, 4'd0, 0,
                (i == 5 || i == 0), (i > 5) ? 8'd0 : (i > 0) ? 8'd1 : 8'd2);
        end
        // ---- 2a: overlap=1, stream 11011011
        add("t2a_load", 0, 0, 1, 0, 8'h1B, 4'd5, 1, 0, 8'd0);
        t2 = 8'b11011011;
        for (int i = 7; i >= 0; i--) begin
            add($sformatf("t2a_bit%0d", 8 - i), 0, 1, 0, t2[i], 8'h00, 4'd0, 0,
                (i == 3 || i == 0), (i > 3) ? 8'd0 : (i > 0) ? 8'd1 : 8'd2);
        end
        // ---- 2b: same stream, overlap=0
        add("t2b_load", 0, 0, 1, 0, 8'h1B, 4'd5, 0, 0, 8'd0);
        for (int i = 7; i >= 0; i--) begin
            add($sformatf("t2b_bit%0d", 8 - i), 0, 1, 0, t2[i], 8'h00, 4'd0, 0,
                (i == 3), (i > 3) ? 8'd0 : 8'd1);
        end
        // ---- 3: enable gating
        add("t3_load", 0, 0, 1, 0, 8'h1B, 4'd5, 0, 0, 8'd0);
        add("t3_b1", 0, 1, 0, 1, 8'h00, 4'd0, 0, 0, 8'd0);
        add("t3_b2", 0, 1, 0, 1, 8'h00, 4'd0, 0, 0, 8'd0);
        add("t3_b3", 0, 1, 0, 0, 8'h00, 4'd0, 0, 0, 8'd0);
        add("t3_gap1", 0, 0, 0, 1, 8'h00, 4'd0, 0, 0, 8'd0);
        add("t3_gap2", 0, 0, 0, 0, 8'h00, 4'd0, 0, 0, 8'd0);
        add("t3_gap3", 0, 0, 0, 1, 8'h00, 4'd0, 0, 0, 8'd0);
        add("t3_b4", 0, 1, 0, 1, 8'h00, 4'd0, 0, 0, 8'd0);
        add("t3_b5", 0, 1, 0, 1, 8'h00, 4'd0, 0, 1, 8'd1);
        add("t3_hold", 0, 0, 0, 1, 8'h00, 4'd0, 0, 0, 8'd1);
        // ---- 4a: A5, len 12 clamped to 8, overlap
        add("t4_load", 0, 0, 1, 0, 8'hA5, 4'd12, 1, 0, 8'd0);
        a5 = 8'b10100101;
        for (int i = 7; i >= 0; i--) begin
            add($sformatf("t4_bit%0d", 8 - i), 0, 1, 0, a5[i], 8'h00, 4'd0, 0,
                (i == 0), (i == 0) ? 8'd1 : 8'd0);
        end
        a5b = 7'b0100101;
        for (int i = 6; i >= 0; i--) begin
            add($sformatf("t4_seed%0d", 7 - i), 0, 1, 0, a5b[i], 8'h00, 4'd0, 0,
                (i == 0), (i == 0) ? 8'd2 : 8'd1);
        end

        // Apply the table.
        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].rst, vecs[k].en, vecs[k].ld, vecs[k].sig,
                 vecs[k].pat, vecs[k].len, vecs[k].ovl);
            check(vecs[k].name, vecs[k].exp_out, vecs[k].exp_cnt);
        end

        // ---- 4b: len=0 keeps the detector idle on a random stream
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 4'd0, 1'b1);
        check("t4b_load", 1'b0, 8'd0);
        for (int i = 0; i < 60; i++) begin
            bit_in("t4b_idle", 1'($urandom_range(1, 0)), 1'b0, 8'd0);
        end

        // ---- 5a: pattern 1, len 1, 300 ones: continuous out, cnt saturates
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 4'd1, 1'b1);
        check("t5_load", 1'b0, 8'd0);
        for (int i = 0; i < 300; i++) begin
            bit_in($sformatf("t5_sat%0d", i), 1'b1, 1'b1, (i >= 254) ? 8'd255 : 8'(i + 1));
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0);
        check("t5_en_low", 1'b0, 8'd255);
        // ---- 5b: cfg_load with en=1 and signal=1: bit ignored
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 4'd1, 1'b1);
        check("t5_ld_prio", 1'b0, 8'd0);
        bit_in("t5_after_ld", 1'b1, 1'b1, 8'd1);

        // ---- 6: mid-pattern reset, defaults restored
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        check("t6_rst0", 1'b0, 8'd0);
        bit_in("t6_p1", 1'b1, 1'b0, 8'd0);
        bit_in("t6_p2", 1'b1, 1'b0, 8'd0);
        bit_in("t6_p3", 1'b0, 1'b0, 8'd0);
        bit_in("t6_p4", 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0);
        check("t6_rst1", 1'b0, 8'd0);
        bit_in("t6_after_rst", 1'b1, 1'b0, 8'd0);
        bit_in("t6_q1", 1'b1, 1'b0, 8'd0);
        bit_in("t6_q2", 1'b1, 1'b0, 8'd0);
        bit_in("t6_q3", 1'b0, 1'b0, 8'd0);
        bit_in("t6_q4", 1'b1, 1'b0, 8'd0);
        bit_in("t6_q5", 1'b1, 1'b1, 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        check("t6_drop", 1'b0, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
